// File: rtl/div_sequencer.sv
// -----------------------------------------------------------------------------
// div_sequencer
//
// Sequences a shared, fixed-latency, pipelined 40-bit divide core for the
// RV32M DIV / DIVU / REM / REMU instructions. It sits between the execute
// stage and the core.
//
// The sequencer:
//   * accepts one request at a time over a valid/ready handshake;
//   * resolves divide-by-zero and signed overflow (MIN / -1) itself, without
//     starting the core;
//   * keeps the full quotient/remainder of the last completed core operation,
//     so that a later request with the same operands and signedness returns
//     in one cycle (e.g. DIV followed by REM);
//   * holds the result until the consumer takes it.
//
// Parameters
//   XLEN         operand/result width
//   DIV_LATENCY  core cycles from operand sample to valid quotient/remainder
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   req_valid      request present
//   req_ready      sequencer can accept (high only in IDLE)
//   req_funct3     100 DIV, 101 DIVU, 110 REM, 111 REMU
//   req_a, req_b   dividend, divisor
//   flush          abort the in-flight or held operation (no response)
//   resp_valid     result available
//   resp_ready     consumer takes the result
//   resp_data      result
//   busy           sequencer not idle (pipeline stall)
//   core_numer     40-bit extended dividend to the core
//   core_denom     40-bit extended divisor to the core
//   core_quotient  40-bit quotient from the core
//   core_remain    40-bit remainder from the core
// -----------------------------------------------------------------------------
module div_sequencer #(
  parameter int XLEN        = 32,
  parameter int DIV_LATENCY = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            busy,
  output logic [39:0]     core_numer,
  output logic [39:0]     core_denom,
  input  logic [39:0]     core_quotient,
  input  logic [39:0]     core_remain
);

  localparam int CORE_W = 40;
  localparam int CNT_W  = $clog2(DIV_LATENCY + 1);

  // The core result is captured on the edge where the count reaches
  // DIV_LATENCY, i.e. while the registered count still holds DIV_LATENCY-1.
  // That places resp_valid DIV_LATENCY+1 cycles after the accept cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_LATENCY - 1);

  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL1 = {XLEN{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Extend an operand to core width: zero-extend unsigned ops, sign-extend
  // signed ones, so a single signed core serves all four instructions.
  function automatic logic [CORE_W-1:0] extend_op(input logic [XLEN-1:0] v,
                                                 input logic             is_u);
    extend_op = is_u ? {{(CORE_W-XLEN){1'b0}}, v}
                     : {{(CORE_W-XLEN){v[XLEN-1]}}, v};
  endfunction

  // Cases the core must never see: divide by zero and signed MIN / -1.
  function automatic logic special_case(input logic            is_u,
                                        input logic [XLEN-1:0] a,
                                        input logic [XLEN-1:0] b);
    special_case = (b == '0) || (!is_u && (a == SMIN) && (b == ALL1));
  endfunction

  // RV32M-defined results for those cases.
  function automatic logic [XLEN-1:0] special_value(input logic            is_rem,
                                                    input logic [XLEN-1:0] a,
                                                    input logic [XLEN-1:0] b);
    if (b == '0) special_value = is_rem ? a : ALL1;
    else         special_value = is_rem ? '0 : SMIN;
  endfunction

  // Registered operation (sampled at accept, drives the core while BUSY).
  logic [XLEN-1:0]  op_a_p0;
  logic [XLEN-1:0]  op_b_p0;
  logic             op_u_p0;
  logic             op_rem_p0;
  logic [CNT_W-1:0] cnt;

  // Result register presented while DONE.
  logic [XLEN-1:0]  result_p1;

  // Last completed core operation.
  logic             cache_valid;
  logic [XLEN-1:0]  cache_a;
  logic [XLEN-1:0]  cache_b;
  logic             cache_u;
  logic [CORE_W-1:0] cache_q;
  logic [CORE_W-1:0] cache_r;

  // Decode of the incoming request.
  logic             req_u;
  logic             req_rem;
  logic             req_special;
  logic             req_hit;
  logic [XLEN-1:0]  req_spec_val;
  logic [XLEN-1:0]  req_hit_val;

  // Funct3[2] only distinguishes M-extension divides from illegal encodings,
  // which never reach this block.
  logic             unused_funct3_msb;
  assign unused_funct3_msb = req_funct3[2];

  assign req_u        = req_funct3[0];
  assign req_rem      = req_funct3[1];
  assign req_special  = special_case(req_u, req_a, req_b);
  assign req_spec_val = special_value(req_rem, req_a, req_b);
  assign req_hit      = cache_valid && (req_a == cache_a) && (req_b == cache_b) &&
                        (req_u == cache_u) && !req_special;
  assign req_hit_val  = req_rem ? cache_r[XLEN-1:0] : cache_q[XLEN-1:0];

  // FSM control strobes.
  logic accept;
  logic capture;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    capture    = 1'b0;
    req_ready  = (state == IDLE);
    resp_valid = (state == DONE);
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        // flush in IDLE suppresses the accept even though req_ready is high.
        if (req_valid && !flush) begin
          accept    = 1'b1;
          state_nxt = (req_special || req_hit) ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (flush) begin
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        // Leaving DONE always goes through IDLE, so a request waiting on
        // req_valid is accepted no earlier than the following cycle.
        if (flush || resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- stage p0: operand capture at accept, latency count while BUSY ----
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a_p0   <= '0;
      op_b_p0   <= '0;
      op_u_p0   <= 1'b0;
      op_rem_p0 <= 1'b0;
      cnt       <= '0;
    end else if (accept) begin
      op_a_p0   <= req_a;
      op_b_p0   <= req_b;
      op_u_p0   <= req_u;
      op_rem_p0 <= req_rem;
      cnt       <= '0;
    end else if (state == BUSY) begin
      cnt       <= cnt + 1'b1;
    end
  end

  // ---- stage p1: result register (special / cache hit / core capture) ----
  always_ff @(posedge clk) begin
    if (rst) begin
      result_p1 <= '0;
    end else if (accept && req_special) begin
      result_p1 <= req_spec_val;
    end else if (accept && req_hit) begin
      result_p1 <= req_hit_val;
    end else if (capture) begin
      result_p1 <= op_rem_p0 ? core_remain[XLEN-1:0] : core_quotient[XLEN-1:0];
    end
  end

  // Only a completed core operation fills the cache; aborted ones never do.
  always_ff @(posedge clk) begin
    if (rst)          cache_valid <= 1'b0;
    else if (capture) cache_valid <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      cache_a <= op_a_p0;
      cache_b <= op_b_p0;
      cache_u <= op_u_p0;
      cache_q <= core_quotient;
      cache_r <= core_remain;
    end
  end

  // Operands are held in registers, so they stay stable for the whole BUSY
  // period; forced to zero while reset is asserted.
  assign core_numer = rst ? '0 : extend_op(op_a_p0, op_u_p0);
  assign core_denom = rst ? '0 : extend_op(op_b_p0, op_u_p0);

  assign resp_data  = (state == DONE) ? result_p1 : '0;

endmodule

// File: tb/tb_div_sequencer.sv
// -----------------------------------------------------------------------------
// tb_div_sequencer
//
// Bench for div_sequencer. A behavioural divide core (signed 40-bit division,
// DIV_LATENCY-1 register stages after the sequencer's own operand registers)
// feeds the DUT. Expected results come from RV32M arithmetic on 64-bit
// integers; expected latency comes from a one-entry model of the last
// completed core operation.
// -----------------------------------------------------------------------------
module tb_div_sequencer;

  localparam int XLEN        = 32;
  localparam int DIV_LATENCY = 8;
  localparam int CORE_STAGES = DIV_LATENCY - 1;
  localparam int MAX_WAIT    = 40;

  localparam logic [2:0] F_DIV  = 3'b100;
  localparam logic [2:0] F_DIVU = 3'b101;
  localparam logic [2:0] F_REM  = 3'b110;
  localparam logic [2:0] F_REMU = 3'b111;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_a;
  logic [XLEN-1:0] req_b;
  logic            flush;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_data;
  logic            busy;
  logic [39:0]     core_numer;
  logic [39:0]     core_denom;
  logic [39:0]     core_quotient;
  logic [39:0]     core_remain;

  int n_checks = 0;
  int n_fail   = 0;

  div_sequencer #(.XLEN(XLEN), .DIV_LATENCY(DIV_LATENCY)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_funct3   (req_funct3),
    .req_a        (req_a),
    .req_b        (req_b),
    .flush        (flush),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_data    (resp_data),
    .busy         (busy),
    .core_numer   (core_numer),
    .core_denom   (core_denom),
    .core_quotient(core_quotient),
    .core_remain  (core_remain)
  );

  always #5 clk = ~clk;

  // Behavioural pipelined core.
  logic signed [39:0] cq [CORE_STAGES];
  logic signed [39:0] cr [CORE_STAGES];

  always @(posedge clk) begin
    if (core_denom == 40'd0) begin
      cq[0] <= '0;
      cr[0] <= '0;
    end else begin
      cq[0] <= $signed(core_numer) / $signed(core_denom);
      cr[0] <= $signed(core_numer) % $signed(core_denom);
    end
    for (int i = 1; i < CORE_STAGES; i++) begin
      cq[i] <= cq[i-1];
      cr[i] <= cr[i-1];
    end
  end

  assign core_quotient = cq[CORE_STAGES-1];
  assign core_remain   = cr[CORE_STAGES-1];

  // Reference model state: last operation that went through the core.
  logic        m_valid;
  logic [31:0] m_a;
  logic [31:0] m_b;
  logic        m_u;

  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
    if (f[0]) begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end
    q = sa / sb;
    r = sa % sb;
    return f[1] ? r[31:0] : q[31:0];
  endfunction

  function automatic int exp_latency(input logic [2:0] f, input logic [31:0] a,
                                     input logic [31:0] b);
    logic special;
    special = (b == 32'd0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    if (special) return 1;
    if (m_valid && a == m_a && b == m_b && f[0] == m_u) return 1;
    return DIV_LATENCY + 1;
  endfunction

  task automatic model_commit(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (exp_latency(f, a, b) != 1) begin
      m_valid = 1'b1;
      m_a     = a;
      m_b     = b;
      m_u     = f[0];
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // One complete transaction: accept, wait for the result, optional
  // backpressure, take. Checks data, latency and busy occupancy.
  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_data, input int exp_lat,
                        input int hold);
    int lat;
    int busy_n;
    logic [31:0] data;
    @(negedge clk);
    req_valid  = 1'b1;
    req_funct3 = f;
    req_a      = a;
    req_b      = b;
    @(posedge clk);
    lat    = 0;
    busy_n = 0;
    do begin
      @(negedge clk);
      req_valid = 1'b0;
      lat++;
      if (busy) busy_n++;
    end while (!resp_valid && lat < MAX_WAIT);
    data = resp_data;
    check($sformatf("%s latency", name), 64'(lat), 64'(exp_lat));
    check($sformatf("%s data", name), {32'd0, data}, {32'd0, exp_data});
    check($sformatf("%s busy cycles", name), 64'(busy_n), 64'(exp_lat));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check($sformatf("%s held data", name), {32'd0, resp_data}, {32'd0, exp_data});
      check($sformatf("%s held valid", name), {63'd0, resp_valid}, 64'd1);
      check($sformatf("%s held req_ready", name), {63'd0, req_ready}, 64'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    model_commit(f, a, b);
  endtask

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs [16];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, actual still running required finished");
    $fatal(1);
  end

  initial begin
    int          lat;
    logic        seen;
    logic [2:0]  f;
    logic [31:0] a, b, last_a, last_b;
    int          sel;

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_funct3 = F_DIV;
    req_a      = '0;
    req_b      = '0;
    flush      = 1'b0;
    resp_ready = 1'b0;
    m_valid    = 1'b0;
    m_a        = '0;
    m_b        = '0;
    m_u        = 1'b0;
    last_a     = 32'd100;
    last_b     = 32'd7;

    vecs[0]  = '{F_DIV,  32'd100,        32'd7,          32'd14,         9};
    vecs[1]  = '{F_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  9};
    vecs[2]  = '{F_REMU, 32'hFFFF_FFF9,  32'd2,          32'd1,          9};
    vecs[3]  = '{F_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};
    vecs[4]  = '{F_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
    vecs[5]  = '{F_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
    vecs[6]  = '{F_DIV,  32'd100,        32'd7,          32'd14,         9};
    vecs[7]  = '{F_REM,  32'd100,        32'd7,          32'd2,          1};
    vecs[8]  = '{F_DIVU, 32'd100,        32'd7,          32'd14,         9};
    vecs[9]  = '{F_REMU, 32'd100,        32'd7,          32'd2,          1};
    vecs[10] = '{F_REM,  32'd5,          32'd0,          32'd5,          1};
    vecs[11] = '{F_REMU, 32'd100,        32'd7,          32'd2,          1};
    vecs[12] = '{F_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          9};
    vecs[13] = '{F_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
    vecs[14] = '{F_DIV,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  9};
    vecs[15] = '{F_REM,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,  1};

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset resp_valid", {63'd0, resp_valid}, 64'd0);
    check("reset resp_data", {32'd0, resp_data}, 64'd0);
    check("reset req_ready", {63'd0, req_ready}, 64'd1);
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset core_numer", {24'd0, core_numer}, 64'd0);
    check("reset core_denom", {24'd0, core_denom}, 64'd0);
    rst = 1'b0;

    // Directed vectors.
    for (int i = 0; i < 16; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, 0);
    end

    // Backpressure: result held for 5 cycles.
    run_op("backpressure", F_DIV, 32'd1000, 32'd10, 32'd100, 9, 5);

    // No same-cycle re-accept when the result is taken.
    @(negedge clk);
    req_valid = 1'b1; req_funct3 = F_REM; req_a = 32'd1000; req_b = 32'd10;
    @(posedge clk);
    @(negedge clk);
    check("reaccept first valid", {63'd0, resp_valid}, 64'd1);
    check("reaccept first data", {32'd0, resp_data}, 64'd0);
    req_funct3 = F_DIV;
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    check("reaccept idle after take", {63'd0, busy}, 64'd0);
    check("reaccept ready after take", {63'd0, req_ready}, 64'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("reaccept second valid", {63'd0, resp_valid}, 64'd1);
    check("reaccept second data", {32'd0, resp_data}, 64'd100);
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;

    // flush together with req_valid in IDLE: not accepted.
    @(negedge clk);
    req_valid = 1'b1; flush = 1'b1; req_funct3 = F_DIV; req_a = 32'd77; req_b = 32'd5;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    check("idle flush no accept", {63'd0, busy}, 64'd0);

    // flush at cnt=3 in BUSY.
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("busy flush busy", {63'd0, busy}, 64'd0);
    check("busy flush resp_valid", {63'd0, resp_valid}, 64'd0);
    check("busy flush req_ready", {63'd0, req_ready}, 64'd1);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    check("busy flush no response", {63'd0, seen}, 64'd0);
    run_op("after flush rem", F_REM, 32'd77, 32'd5, 32'd2, 9, 0);
    run_op("after flush div", F_DIV, 32'd77, 32'd5, 32'd15, 1, 0);

    // flush with resp_ready in DONE: treated as flush; cache already loaded.
    @(negedge clk);
    req_valid = 1'b1; req_funct3 = F_DIV; req_a = 32'd64; req_b = 32'd8;
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      req_valid = 1'b0;
      lat++;
    end while (!resp_valid && lat < MAX_WAIT);
    check("done flush latency", 64'(lat), 64'(DIV_LATENCY + 1));
    flush = 1'b1; resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; resp_ready = 1'b0;
    check("done flush resp_valid", {63'd0, resp_valid}, 64'd0);
    check("done flush busy", {63'd0, busy}, 64'd0);
    model_commit(F_DIV, 32'd64, 32'd8);
    run_op("after done flush", F_REM, 32'd64, 32'd8, 32'd0, 1, 0);

    // rst at cnt=3: abort, reset outputs, cache cleared.
    @(negedge clk);
    req_valid = 1'b1; req_funct3 = F_DIV; req_a = 32'd999; req_b = 32'd4;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid rst resp_valid", {63'd0, resp_valid}, 64'd0);
    check("mid rst resp_data", {32'd0, resp_data}, 64'd0);
    check("mid rst req_ready", {63'd0, req_ready}, 64'd1);
    check("mid rst busy", {63'd0, busy}, 64'd0);
    check("mid rst core_numer", {24'd0, core_numer}, 64'd0);
    check("mid rst core_denom", {24'd0, core_denom}, 64'd0);
    rst     = 1'b0;
    m_valid = 1'b0;
    run_op("after rst", F_REM, 32'd64, 32'd8, 32'd0, 9, 0);

    // Randomized operations against the reference model.
    for (int n = 0; n < 200; n++) begin
      f   = {1'b1, 2'($urandom_range(0, 3))};
      sel = $urandom_range(0, 9);
      if (sel < 3) begin
        a = last_a;
        b = last_b;
      end else begin
        case ($urandom_range(0, 4))
          0:       a = 32'h8000_0000;
          1:       a = 32'hFFFF_FFF9;
          2:       a = $urandom_range(0, 200);
          default: a = $urandom;
        endcase
        case ($urandom_range(0, 4))
          0:       b = 32'd0;
          1:       b = 32'hFFFF_FFFF;
          2:       b = $urandom_range(1, 20);
          default: b = $urandom;
        endcase
      end
      last_a = a;
      last_b = b;
      run_op($sformatf("rand%0d", n), f, a, b, ref_result(f, a, b), exp_latency(f, a, b),
             $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
- Controller that sequences the shared fixed-latency pipelined 40-bit divide core for RV32M DIV/DIVU/REM/REMU.
- Sits between the execute stage and the divide core:
  - accepts one request at a time through a valid/ready handshake;
  - resolves divide-by-zero and signed overflow without using the core;
  - reuses the last quotient/remainder pair when a later request has the same operands;
  - holds the result until the consumer takes it.

Parameters:
- XLEN, 32, operand/result width.
- DIV_LATENCY, 8, core cycles from operand sample to valid quotient/remainder (1..14).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept.
- req_funct3  in  3  100 DIV, 101 DIVU, 110 REM, 111 REMU.
- req_a  in  XLEN  dividend.
- req_b  in  XLEN  divisor.
- flush  in  1  abort in-flight/held op.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer takes result.
- resp_data  out  XLEN  result.
- busy  out  1  state != IDLE (pipeline stall).
- core_numer  out  40  to core.
- core_denom  out  40  to core.
- core_quotient  in  40  from core.
- core_remain  in  40  from core.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values:
  - state IDLE; cnt 0; cache_valid 0; operand/result regs 0.
  - Outputs: resp_valid 0, resp_data 0, req_ready 1, busy 0.
  - core_numer and core_denom are 0 during reset.
- rst mid-operation aborts the operation; no response is produced.
- States:
  - IDLE: req_ready=1.
  - BUSY: counting core latency.
  - DONE: resp_valid=1, resp_data driven from the result register.
- Accept happens when req_valid && req_ready, which implies IDLE. On accept, funct3, a and b are registered.
  - Let u = funct3[0] and signed = !u.
  - core_numer/denom come from the registered operands. They are sign-extended to 40 bits when signed and zero-extended when u=1.
  - They stay stable for the whole BUSY period.
- Special cases, decided at accept from the raw inputs:
  - b==0: DIV/DIVU give 0xFFFF_FFFF; REM/REMU give a.
  - Signed op with a==0x8000_0000 and b==0xFFFF_FFFF: DIV gives 0x8000_0000; REM gives 0.
  - A special case goes IDLE->DONE directly with the value loaded. resp_valid is high in the cycle after accept.
- Cache hit:
  - Condition: cache_valid, a==cache_a, b==cache_b, funct3[0]==cache_u, and not a special case.
  - Goes IDLE->DONE directly. The result is cache_q (funct3[1]=0) or cache_r (funct3[1]=1). Latency 1.
- Normal request: IDLE->BUSY with cnt=0. cnt increments each BUSY cycle.
- On the edge where cnt==DIV_LATENCY:
  - Capture core_quotient[XLEN-1:0] or core_remain[XLEN-1:0] into the result register.
  - Load the cache: a, b, u, full q and r; set cache_valid=1.
  - Go to DONE.
  - resp_valid first asserts DIV_LATENCY+1 cycles after the accept cycle.
- DONE:
  - Holds resp_data stable while resp_ready=0.
  - resp_valid && resp_ready returns the sequencer to IDLE.
  - The next request is accepted no earlier than the following cycle; no same-cycle re-accept.
- flush (lower priority than rst, higher than everything else):
  - In BUSY or DONE: go to IDLE next cycle; no response; cache unchanged (an aborted BUSY does not load it).
  - In IDLE together with req_valid: the request is not accepted.
  - flush with resp_ready in DONE: treated as flush.
- cache_valid is cleared only by rst. Cache entries are only ever produced by completed core operations.
- req_funct3[2]==0 is illegal. The requester never presents it; behaviour is undefined.

Test Plan:
- DIV a=100, b=7 → resp_valid at accept+9 cycles (DIV_LATENCY=8), data=14; busy high for 9 cycles.
- REM a=0xFFFF_FFF9 (-7), b=2 → 0xFFFF_FFFF; then REMU with the same operands → 1 after 9 cycles, since the cache misses on the u mismatch.
- DIVU a=5, b=0 → data 0xFFFF_FFFF at accept+1. REM a=0x8000_0000, b=0xFFFF_FFFF → 0 at accept+1, and the core is not used.
- DIV a=0x8000_0000, b=0xFFFF_FFFF → 0x8000_0000 at accept+1.
- DIV 100/7 completes, then REM 100/7 → data 2 at accept+1 (cache hit).
- Backpressure and flush:
  - resp_ready held 0 for 5 cycles in DONE → resp_data stable, req_ready 0.
  - flush at BUSY cnt=3 → IDLE next cycle, no resp_valid. A following REM on the same operands takes the full latency (cache not loaded).
  - rst at cnt=3 → IDLE, all outputs at reset values.
